rdout_train_ctrl: RTL and testbench
===================================

# rdout_train_ctrl

Sequencer for the readout training loop. On a start request it streams sample addresses to the readout's target-output ROM, which sees them in phase with the reservoir state stream. It holds the readout clock-enable high for a programmed number of epochs plus the pipeline drain, then drops it so the readout locks the learned output weights. It sits between the top-level host/test logic and the reservoir + readout pair, and is the only driver of their `ce` and `addr` inputs.

## Interface
- `ADDR_W`, 6, sample address width
- `N_SAMPLES`, 64, samples per epoch (≤ 2^ADDR_W)
- `EPOCH_W`, 8, epoch counter width
- `PIPE_LAT`, 4, reservoir-to-readout latency in cycles, ≥ 1
- `EST_W`, 32, estimate/target width (signed)
- `ERR_W`, 40, epoch error accumulator width
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  start request, sampled in IDLE only
- `abort`  in  1  abandon run; dominates `start`
- `n_epochs`  in  EPOCH_W  epoch count, captured when `start` is accepted
- `err_thresh`  in  ERR_W  early-stop threshold, unsigned, captured when `start` is accepted
- `est`  in  EST_W  readout predicted output
- `y_true`  in  EST_W  target aligned with `est`
- `addr`  out  ADDR_W  sample address to reservoir/ROM
- `res_ce`  out  1  reservoir advance enable
- `rdout_ce`  out  1  readout output/weight-register enable
- `est_valid`  out  1  `est`/`y_true` belong to an issued sample
- `epoch`  out  EPOCH_W  current epoch index
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `early_stop`  out  1  sticky; last run ended on threshold, cleared at next accepted start

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: all outputs 0. `start`=1 and `abort`=0 → capture `n_epochs`/`err_thresh`, clear `early_stop`. Go to RUN, or to DONE if `n_epochs`=0 (no address issued).
- RUN: `res_ce`=`rdout_ce`=1.
  - `addr` increments each cycle from 0.
  - At `N_SAMPLES-1`: `addr` wraps to 0 and `epoch`+1.
  - After the issue of `addr`=`N_SAMPLES-1` in epoch `n_epochs-1`, or in any epoch with the stop flag set → DRAIN.
- DRAIN: `res_ce`=0, `addr` holds, `rdout_ce`=1 for exactly `PIPE_LAT` cycles → DONE.
- DONE: `done`=1 for one cycle, `rdout_ce`=0 → IDLE. `epoch` holds its final value until the next start.
- Issue-valid shift register, depth `PIPE_LAT`, input = (state==RUN); its output is `est_valid`.
- `abort` in any non-IDLE state: next cycle IDLE, `rdout_ce`=0, no `done`, issue-valid pipe cleared.
- `start` while busy is ignored.
- Reset at any point is equivalent to abort and also clears `epoch` and `early_stop`.

## Timing
- `start` accepted at cycle 0. RUN at cycle 1 with `addr`=0. Sample k issued at cycle 1+k.
- `est_valid` is high on cycles 1+PIPE_LAT through 1+PIPE_LAT+T-1, where T = total samples issued.
- DRAIN cycles: 1+T … T+PIPE_LAT. `done` at cycle T+PIPE_LAT+1.
- Worst-case `done` latency: `n_epochs`·N_SAMPLES + PIPE_LAT + 1 cycles.
- `rdout_ce` falls in the same cycle `done` rises.

## Configuration
- `RDOUT_EARLY_STOP_EN` defined:
  - Saturating unsigned accumulator adds |y_true − est| (EST_W+1-bit difference, magnitude) on each `est_valid` cycle.
  - When the `est_valid` sample with address `N_SAMPLES-1` is consumed: if sum < `err_thresh`, set the stop flag and `early_stop`. The accumulator clears on that cycle.
  - The epoch currently being issued completes, then DRAIN.
  - A threshold hit during the last epoch is still reported on `early_stop`.
- Undefined: no accumulator. `err_thresh`, `est`, `y_true` are ignored and `early_stop` is tied to 0.

## Structure
- Package `rdout_pkg`: state enum (IDLE/RUN/DRAIN/DONE), default `ADDR_W`, `N_SAMPLES`, `PIPE_LAT`, `EST_W`.
- One sub-module: `rdout_err_accum` (abs-diff plus saturating accumulator, clear input). Instantiated only under `RDOUT_EARLY_STOP_EN`.

## Test plan
- `n_epochs`=2, N_SAMPLES=64, PIPE_LAT=4, start at cycle 0:
  - `addr` runs 0..63,0..63 on cycles 1–128.
  - `epoch` goes 0→1 at cycle 65.
  - `est_valid` is high on cycles 5–132.
  - `done` at cycle 133.
  - `rdout_ce` is high on cycles 1–132.
- `n_epochs`=0: `done` at cycle 2; `res_ce`, `rdout_ce`, `est_valid` never assert.
- `abort` at cycle 40 of a 3-epoch run:
  - IDLE at cycle 41, all outputs 0 except `epoch`, no `done`.
  - A new start at cycle 45 begins again at `addr`=0.
- `start` pulsed during RUN: no effect on `addr` sequence or `done` timing. `rst` at cycle 70: cycle 71 all outputs 0, `epoch`=0.
- Early stop (`RDOUT_EARLY_STOP_EN`), `n_epochs`=5, `err_thresh`=100:
  - Drive |y_true−est|=1 on every valid sample, so each epoch sum is 64 < 100.
  - Stop flag set at cycle 68; run ends after epoch 1 (128 samples).
  - `done` at cycle 133; `early_stop`=1.
- Same run with `err_thresh`=64 (64 is not < 64): full 5 epochs run, `done` at cycle 325, `early_stop`=0. Saturation check: drive est=−2^31, y_true=2^31−1 and confirm the accumulator clamps at 2^40−1.

Source files
------------

// File: rtl/rdout_pkg.sv
// Shared types and default sizing for the readout training sequencer.
package rdout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_N_SAMPLES = 64;
  localparam int DEF_EPOCH_W   = 8;
  localparam int DEF_PIPE_LAT  = 4;
  localparam int DEF_EST_W     = 32;
  localparam int DEF_ERR_W     = 40;

endpackage

// File: rtl/rdout_train_ctrl_if.sv
// Host and reservoir/readout bundle of rdout_train_ctrl; `state` is a debug tap of the sequencer FSM.
interface rdout_train_ctrl_if
  import rdout_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int EPOCH_W = DEF_EPOCH_W,
  parameter int EST_W   = DEF_EST_W,
  parameter int ERR_W   = DEF_ERR_W
);
  // start is a level request taken only in IDLE (abort wins); done is a one-cycle pulse, busy covers the run.
  logic               start;
  logic               abort;
  logic [EPOCH_W-1:0] n_epochs;
  logic [ERR_W-1:0]   err_thresh;
  logic [EST_W-1:0]   est;
  logic [EST_W-1:0]   y_true;
  logic [ADDR_W-1:0]  addr;
  logic               res_ce;
  logic               rdout_ce;
  logic               est_valid;
  logic [EPOCH_W-1:0] epoch;
  logic               busy;
  logic               done;
  logic               early_stop;
  state_t             state;

  modport master (
    output start, abort, n_epochs, err_thresh, est, y_true,
    input  addr, res_ce, rdout_ce, est_valid, epoch, busy, done, early_stop, state
  );

  modport slave (
    input  start, abort, n_epochs, err_thresh, est, y_true,
    output addr, res_ce, rdout_ce, est_valid, epoch, busy, done, early_stop, state
  );

endinterface

// File: rtl/rdout_err_accum.sv
// Absolute error |y_true - est| summed into a saturating unsigned accumulator with synchronous clear.
module rdout_err_accum #(
  parameter int EST_W = 32,
  parameter int ERR_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [EST_W-1:0] est,
  input  logic [EST_W-1:0] y_true,
  output logic [ERR_W-1:0] sum_nxt
);

  logic [EST_W:0]   diff;
  logic [EST_W:0]   mag;
  logic [ERR_W:0]   wide;
  logic [ERR_W-1:0] acc;

  // sum_nxt already includes the current sample so the epoch-end compare sees the full epoch
  always_comb begin
    diff    = {y_true[EST_W-1], y_true} - {est[EST_W-1], est};
    mag     = diff[EST_W] ? (~diff + (EST_W+1)'(1)) : diff;
    wide    = {1'b0, acc} + (ERR_W+1)'(en ? mag : '0);
    sum_nxt = wide[ERR_W] ? '1 : wide[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= sum_nxt;
  end

endmodule

// File: rtl/rdout_train_ctrl.sv
// Readout training sequencer: streams sample addresses for n_epochs, drains the pipe, then locks the readout.
// Optional early stop on per-epoch error is built when RDOUT_EARLY_STOP_EN is defined.
module rdout_train_ctrl
  import rdout_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int EPOCH_W   = DEF_EPOCH_W,
  parameter int PIPE_LAT  = DEF_PIPE_LAT,
  parameter int EST_W     = DEF_EST_W,
  parameter int ERR_W     = DEF_ERR_W
) (
  input logic clk,
  input logic rst,
  rdout_train_ctrl_if.slave bus
);

  localparam int DC_W = $clog2(PIPE_LAT + 1);

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [EPOCH_W-1:0] epoch;
  logic [EPOCH_W-1:0] n_ep_q;
  logic [DC_W-1:0]    drain_cnt;
  logic               res_ce, rdout_ce, done, early_stop, stop_q;
  logic [PIPE_LAT-1:0] vld_sr;
  logic               last_addr, accept, abort_run, stop_hit;

  assign last_addr = (addr == ADDR_W'(N_SAMPLES - 1));
  assign accept    = (state == IDLE) && bus.start && !bus.abort;
  assign abort_run = bus.abort && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      epoch      <= '0;
      n_ep_q     <= '0;
      drain_cnt  <= '0;
      res_ce     <= 1'b0;
      rdout_ce   <= 1'b0;
      done       <= 1'b0;
      early_stop <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      if (stop_hit) begin
        stop_q     <= 1'b1;
        early_stop <= 1'b1;
      end
      case (state)
        IDLE: if (accept) begin
          n_ep_q     <= bus.n_epochs;
          epoch      <= '0;
          addr       <= '0;
          early_stop <= 1'b0;
          stop_q     <= 1'b0;
          if (bus.n_epochs == '0) begin
            state <= DONE;
          end else begin
            state    <= RUN;
            res_ce   <= 1'b1;
            rdout_ce <= 1'b1;
          end
        end
        RUN: if (last_addr) begin
          if (epoch == n_ep_q - EPOCH_W'(1) || stop_q || stop_hit) begin
            state     <= DRAIN;
            res_ce    <= 1'b0;
            drain_cnt <= '0;
          end else begin
            addr  <= '0;
            epoch <= epoch + EPOCH_W'(1);
          end
        end else begin
          addr <= addr + ADDR_W'(1);
        end
        DRAIN: if (drain_cnt == DC_W'(PIPE_LAT - 1)) begin
          state    <= DONE;
          rdout_ce <= 1'b0;
          done     <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt + DC_W'(1);
        end
        // A zero-epoch run enters DONE with done low and raises it one cycle later
        DONE: if (done) begin
          state <= IDLE;
          done  <= 1'b0;
          addr  <= '0;
        end else begin
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (abort_run) begin
        state    <= IDLE;
        res_ce   <= 1'b0;
        rdout_ce <= 1'b0;
        done     <= 1'b0;
        addr     <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort_run) vld_sr <= '0;
    else                  vld_sr <= (vld_sr << 1) | PIPE_LAT'(state == RUN);
  end

`ifdef RDOUT_EARLY_STOP_EN
  logic [PIPE_LAT-1:0] last_sr;
  logic [ERR_W-1:0]    thresh_q, sum_nxt;
  logic                sample_last, acc_clr;

  assign sample_last = vld_sr[PIPE_LAT-1] && last_sr[PIPE_LAT-1];
  assign acc_clr     = sample_last || (state == IDLE);
  assign stop_hit    = sample_last && (sum_nxt < thresh_q);

  always_ff @(posedge clk) begin
    if (rst || abort_run) last_sr <= '0;
    else                  last_sr <= (last_sr << 1) | PIPE_LAT'(state == RUN && last_addr);
    if (rst)         thresh_q <= '0;
    else if (accept) thresh_q <= bus.err_thresh;
  end

  rdout_err_accum #(.EST_W(EST_W), .ERR_W(ERR_W)) u_accum (
    .clk    (clk),
    .rst    (rst),
    .en     (vld_sr[PIPE_LAT-1]),
    .clr    (acc_clr),
    .est    (bus.est),
    .y_true (bus.y_true),
    .sum_nxt(sum_nxt)
  );
`else
  logic unused_inputs;
  assign unused_inputs = ^{bus.est, bus.y_true, bus.err_thresh};
  assign stop_hit      = 1'b0;
`endif

  assign bus.addr       = addr;
  assign bus.res_ce     = res_ce;
  assign bus.rdout_ce   = rdout_ce;
  assign bus.est_valid  = vld_sr[PIPE_LAT-1];
  assign bus.epoch      = epoch;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done;
  assign bus.early_stop = early_stop;
  assign bus.state      = state;

endmodule

// File: tb/tb_rdout_train_ctrl.sv
// Bench for rdout_train_ctrl: run-level timeline model, abort/reset scenarios, accumulator saturation.
module tb_rdout_train_ctrl;
  import rdout_pkg::*;

  localparam int ADDR_W  = 6;
  localparam int N       = 64;
  localparam int EPOCH_W = 8;
  localparam int P       = 4;
  localparam int EST_W   = 32;
  localparam int ERR_W   = 40;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rdout_train_ctrl_if #(.ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W), .EST_W(EST_W), .ERR_W(ERR_W)) bus ();

  rdout_train_ctrl #(
    .ADDR_W(ADDR_W), .N_SAMPLES(N), .EPOCH_W(EPOCH_W),
    .PIPE_LAT(P), .EST_W(EST_W), .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef RDOUT_EARLY_STOP_EN
  logic             sat_en, sat_clr;
  logic [EST_W-1:0] sat_est, sat_y;
  logic [ERR_W-1:0] sat_sum;

  rdout_err_accum #(.EST_W(EST_W), .ERR_W(ERR_W)) sat_u (
    .clk(clk), .rst(rst), .en(sat_en), .clr(sat_clr),
    .est(sat_est), .y_true(sat_y), .sum_nxt(sat_sum)
  );
`endif

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.n_epochs = '0;
    bus.err_thresh = '0; bus.est = '0; bus.y_true = '0;
`ifdef RDOUT_EARLY_STOP_EN
    sat_en = 1'b0; sat_clr = 1'b1; sat_est = '0; sat_y = '0;
`endif
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.res_ce, bus.rdout_ce, bus.est_valid, bus.done, bus.early_stop} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000",
        {bus.busy, bus.res_ce, bus.rdout_ce, bus.est_valid, bus.done, bus.early_stop});
    end
    total++;
    if (bus.addr !== '0 || bus.epoch !== '0) begin
      bad++; $display("FAIL reset_addr_epoch got=%0d/%0d exp=0/0", bus.addr, bus.epoch);
    end
    rst = 1'b0;
  endtask

  // Timeline model: a run issuing T samples is RUN on 1..T, valid on 1+P..T+P, done at T+P+1.
  task automatic test_runs();
    int n_tab[4] = '{2, 0, 5, 5};
    int th_tab[4] = '{0, 0, 100, 64};
    int n, issued, tt, t_done, idx, v;
    int dif[];
    longint unsigned thr, s;
    bit rnd, exp_es, noise;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_a;
    for (int c = 0; c < 12; c++) begin
      rnd = (c >= 4);
      n   = rnd ? int'($urandom_range(0, 4)) : n_tab[c];
      thr = rnd ? longint'($urandom_range(40, 160)) : longint'(th_tab[c]);
      dif = new[n * N];
      foreach (dif[i]) dif[i] = rnd ? int'($urandom_range(0, 3)) : 1;
      issued = n;
      exp_es = 1'b0;
`ifdef RDOUT_EARLY_STOP_EN
      for (int e = 0; e < n; e++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(dif[e * N + k]);
        if (!exp_es && s < thr) begin
          exp_es = 1'b1;
          issued = (e + 2 < n) ? e + 2 : n;
        end
      end
`endif
      tt     = issued * N;
      t_done = (tt == 0) ? 2 : tt + P + 1;
      exp_q.delete();
      for (int k = 0; k < tt; k++) exp_q.push_back(ADDR_W'(k % N));

      @(negedge clk);
      bus.start = 1'b1; bus.abort = 1'b0;
      bus.n_epochs = EPOCH_W'(n); bus.err_thresh = ERR_W'(thr);
      for (int t = 1; t <= t_done + 2; t++) begin
        @(negedge clk);
        noise = (t < t_done) && ($urandom_range(0, 7) == 0);
        bus.start = noise;
        if (noise) bus.n_epochs = EPOCH_W'($urandom_range(0, 255));
        idx = t - 1 - P;
        if (idx >= 0 && idx < tt) begin
          v = int'($urandom_range(0, 2000)) - 1000;
          bus.est    = v;
          bus.y_true = ($urandom_range(0, 1) == 1) ? v + dif[idx] : v - dif[idx];
        end else begin
          bus.est = $urandom; bus.y_true = $urandom;
        end
        total++;
        if (bus.busy !== (t <= t_done)) begin
          bad++; $display("FAIL run%0d busy t=%0d got=%b exp=%b", c, t, bus.busy, t <= t_done);
        end
        total++;
        if (bus.res_ce !== (t <= tt)) begin
          bad++; $display("FAIL run%0d res_ce t=%0d got=%b exp=%b", c, t, bus.res_ce, t <= tt);
        end
        total++;
        if (bus.rdout_ce !== (tt > 0 && t <= tt + P)) begin
          bad++; $display("FAIL run%0d rdout_ce t=%0d got=%b exp=%b", c, t, bus.rdout_ce, tt > 0 && t <= tt + P);
        end
        total++;
        if (bus.est_valid !== (t >= 1 + P && t <= tt + P)) begin
          bad++; $display("FAIL run%0d est_valid t=%0d got=%b exp=%b", c, t, bus.est_valid, t >= 1 + P && t <= tt + P);
        end
        total++;
        if (bus.done !== (t == t_done)) begin
          bad++; $display("FAIL run%0d done t=%0d got=%b exp=%b", c, t, bus.done, t == t_done);
        end
        if (t <= tt) begin
          exp_a = exp_q.pop_front();
          total++;
          if (bus.addr !== exp_a) begin
            bad++; $display("FAIL run%0d addr t=%0d got=%0d exp=%0d", c, t, bus.addr, exp_a);
          end
          total++;
          if (bus.epoch !== EPOCH_W'((t - 1) / N)) begin
            bad++; $display("FAIL run%0d epoch t=%0d got=%0d exp=%0d", c, t, bus.epoch, (t - 1) / N);
          end
        end
        if (t > t_done) begin
          total++;
          if (bus.addr !== '0) begin
            bad++; $display("FAIL run%0d idle_addr t=%0d got=%0d exp=0", c, t, bus.addr);
          end
        end
        if (t == 1 || t >= t_done) begin
          total++;
          if (bus.early_stop !== (t == 1 ? 1'b0 : exp_es)) begin
            bad++; $display("FAIL run%0d early_stop t=%0d got=%b exp=%b", c, t, bus.early_stop, t == 1 ? 1'b0 : exp_es);
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b0; bus.n_epochs = 8'd3;
    for (int t = 1; t <= 49; t++) begin
      @(negedge clk);
      bus.start = (t == 45) || (t == 48);
      bus.abort = (t == 40) || (t == 47) || (t == 48);
      if (t == 40) begin
        total++;
        if (bus.addr !== ADDR_W'(39) || bus.res_ce !== 1'b1) begin
          bad++; $display("FAIL abort_pre addr=%0d res_ce=%b exp=39/1", bus.addr, bus.res_ce);
        end
      end
      if (t == 41) begin
        total++;
        if ({bus.busy, bus.res_ce, bus.rdout_ce, bus.est_valid, bus.done} !== 5'b0 || bus.addr !== '0) begin
          bad++; $display("FAIL abort_idle flags=%b addr=%0d exp=00000/0",
            {bus.busy, bus.res_ce, bus.rdout_ce, bus.est_valid, bus.done}, bus.addr);
        end
      end
      if (t >= 42 && t <= 45) begin
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
          bad++; $display("FAIL abort_quiet t=%0d done=%b busy=%b exp=0/0", t, bus.done, bus.busy);
        end
      end
      if (t == 46 || t == 47) begin
        total++;
        if (bus.addr !== ADDR_W'(t - 46) || bus.res_ce !== 1'b1) begin
          bad++; $display("FAIL restart t=%0d addr=%0d res_ce=%b exp=%0d/1", t, bus.addr, bus.res_ce, t - 46);
        end
      end
      if (t == 49) begin
        total++;
        if (bus.busy !== 1'b0) begin
          bad++; $display("FAIL abort_dominates busy got=%b exp=0", bus.busy);
        end
      end
    end
    bus.start = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic test_rst_mid_run();
    @(negedge clk);
    bus.start = 1'b1; bus.n_epochs = 8'd3;
    for (int t = 1; t <= 72; t++) begin
      @(negedge clk);
      bus.start = (t == 20);
      rst = (t == 70);
      if (t <= 70) begin
        total++;
        if (bus.addr !== ADDR_W'((t - 1) % N)) begin
          bad++; $display("FAIL rst_run_addr t=%0d got=%0d exp=%0d", t, bus.addr, (t - 1) % N);
        end
      end
      if (t == 71) begin
        total++;
        if ({bus.busy, bus.res_ce, bus.rdout_ce, bus.est_valid, bus.done, bus.early_stop} !== 6'b0
            || bus.addr !== '0 || bus.epoch !== '0) begin
          bad++; $display("FAIL rst_mid flags=%b addr=%0d epoch=%0d exp=000000/0/0",
            {bus.busy, bus.res_ce, bus.rdout_ce, bus.est_valid, bus.done, bus.early_stop}, bus.addr, bus.epoch);
        end
      end
    end
  endtask

`ifdef RDOUT_EARLY_STOP_EN
  task automatic test_saturation();
    longint unsigned m, mx, e;
    m  = 64'hFFFF_FFFF;
    mx = 64'hFF_FFFF_FFFF;
    @(negedge clk);
    sat_clr = 1'b1; sat_en = 1'b0;
    @(negedge clk);
    sat_clr = 1'b0; sat_en = 1'b1; sat_est = 32'h8000_0000; sat_y = 32'h7FFF_FFFF;
    for (int k = 1; k <= 260; k++) begin
      #1;
      e = (longint'(k) * m > mx) ? mx : longint'(k) * m;
      total++;
      if (sat_sum !== ERR_W'(e)) begin
        bad++; $display("FAIL saturate k=%0d got=%0h exp=%0h", k, sat_sum, e);
      end
      @(negedge clk);
    end
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0; sat_est = 32'd100; sat_y = -32'sd25;
    for (int k = 1; k <= 2; k++) begin
      #1;
      total++;
      if (sat_sum !== ERR_W'(125 * k)) begin
        bad++; $display("FAIL neg_diff k=%0d got=%0d exp=%0d", k, sat_sum, 125 * k);
      end
      @(negedge clk);
    end
    sat_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_runs();
    test_abort();
    test_rst_mid_run();
`ifdef RDOUT_EARLY_STOP_EN
    test_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
